// File: rtl/axi_mem_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_if_pkg
//  Description : Shared types and encodings for the AXI4 memory interface
//                write-side controller: FSM state type, B-channel response
//                codes and AXI burst type encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_mem_if_pkg;

    // Write controller state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    // B channel response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AW burst type encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi_write_only_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_write_only_ctrl_if
//  Description : Bundle of the AXI4 AW/W/B channels, the single-port SRAM
//                write port and the arbiter request/grant pair used by the
//                write-side memory controller.
//                slave  : controller view (AXI inputs, memory/B outputs)
//                master : AXI master / environment view
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_write_only_ctrl_if #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_WDATA_WIDTH   = 64,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10,
    parameter int AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH     = 13
);
    // AW channel
    logic [AXI4_ID_WIDTH-1:0]      AWID_i;
    logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i;
    logic [7:0]                    AWLEN_i;
    logic [2:0]                    AWSIZE_i;
    logic [1:0]                    AWBURST_i;
    logic                          AWLOCK_i;
    logic [3:0]                    AWCACHE_i;
    logic [2:0]                    AWPROT_i;
    logic [3:0]                    AWREGION_i;
    logic [3:0]                    AWQOS_i;
    logic [AXI4_USER_WIDTH-1:0]    AWUSER_i;
    logic                          AWVALID_i;
    logic                          AWREADY_o;
    // W channel
    logic [AXI4_WDATA_WIDTH-1:0]   WDATA_i;
    logic [AXI_NUMBYTES-1:0]       WSTRB_i;
    logic                          WLAST_i;
    logic [AXI4_USER_WIDTH-1:0]    WUSER_i;
    logic                          WVALID_i;
    logic                          WREADY_o;
    // B channel
    logic [AXI4_ID_WIDTH-1:0]      BID_o;
    logic [1:0]                    BRESP_o;
    logic [AXI4_USER_WIDTH-1:0]    BUSER_o;
    logic                          BVALID_o;
    logic                          BREADY_i;
    // SRAM write port and arbiter handshake
    logic                          MEM_CEN_o;
    logic                          MEM_WEN_o;
    logic [MEM_ADDR_WIDTH-1:0]     MEM_A_o;
    logic [AXI4_WDATA_WIDTH-1:0]   MEM_D_o;
    logic [AXI_NUMBYTES-1:0]       MEM_BE_o;
    logic                          grant_i;
    logic                          valid_o;

    modport slave (
        input  AWID_i, AWADDR_i, AWLEN_i, AWSIZE_i, AWBURST_i, AWLOCK_i,
               AWCACHE_i, AWPROT_i, AWREGION_i, AWQOS_i, AWUSER_i, AWVALID_i,
        output AWREADY_o,
        input  WDATA_i, WSTRB_i, WLAST_i, WUSER_i, WVALID_i,
        output WREADY_o,
        output BID_o, BRESP_o, BUSER_o, BVALID_o,
        input  BREADY_i,
        output MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o,
        input  grant_i,
        output valid_o
    );

    modport master (
        output AWID_i, AWADDR_i, AWLEN_i, AWSIZE_i, AWBURST_i, AWLOCK_i,
               AWCACHE_i, AWPROT_i, AWREGION_i, AWQOS_i, AWUSER_i, AWVALID_i,
        input  AWREADY_o,
        output WDATA_i, WSTRB_i, WLAST_i, WUSER_i, WVALID_i,
        input  WREADY_o,
        input  BID_o, BRESP_o, BUSER_o, BVALID_o,
        output BREADY_i,
        input  MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o,
        output grant_i,
        input  valid_o
    );

endinterface
`default_nettype wire

// File: rtl/axi_write_only_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : axi_write_only_ctrl
//  Description : AXI4 write-only slave. Each AW burst is turned into one
//                single-port SRAM write per granted W beat; a single B
//                response closes each burst. Memory access is shared with
//                the read half through an external arbiter (valid_o/grant_i,
//                grant returned in the same cycle).
//  Ports       : clk, rst (sync, active high)
//                axi.slave - AW/W/B channels, SRAM write port
//                            (MEM_CEN/WEN active low, MEM_A word address,
//                            MEM_D/MEM_BE straight from WDATA/WSTRB) and the
//                            arbiter valid_o/grant_i pair
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_write_only_ctrl
    import axi_mem_if_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_WDATA_WIDTH   = 64,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10,
    parameter int AXI_NUMBYTES       = AXI4_WDATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH     = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_write_only_ctrl_if.slave  axi
);

    // Byte offset of a full-width beat inside the AXI byte address
    localparam int OFFSET_BIT = $clog2(AXI_NUMBYTES);

    // ------------------------------------------------------------------
    // Registered state and next-state values
    // ------------------------------------------------------------------
    state_t                     r_state, w_state_nxt;
    logic [MEM_ADDR_WIDTH-1:0]  r_addr,  w_addr_nxt;
    logic [7:0]                 r_len,   w_len_nxt;
    logic [7:0]                 r_cnt,   w_cnt_nxt;
    logic                       r_fixed, w_fixed_nxt;
    logic [AXI4_ID_WIDTH-1:0]   r_id,    w_id_nxt;
    logic [AXI4_USER_WIDTH-1:0] r_user,  w_user_nxt;
    logic                       r_err,   w_err_nxt;

    // Combinational outputs
    logic       w_awready;
    logic       w_wready;
    logic       w_bvalid;
    logic [1:0] w_bresp;
    logic       w_valid;
    logic       w_cen;
    logic       w_wen;

    logic                      w_aw_take;
    logic                      w_beat_ok;
    logic                      w_last_beat;
    logic [MEM_ADDR_WIDTH-1:0] w_aw_word;

    assign w_aw_word   = axi.AWADDR_i[MEM_ADDR_WIDTH+OFFSET_BIT-1:OFFSET_BIT];
    assign w_beat_ok   = axi.WVALID_i & axi.grant_i;
    assign w_last_beat = (r_cnt == r_len);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_id    <= '0;
            r_user  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fixed <= w_fixed_nxt;
            r_id    <= w_id_nxt;
            r_user  <= w_user_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_fixed_nxt = r_fixed;
        w_id_nxt    = r_id;
        w_user_nxt  = r_user;
        w_err_nxt   = r_err;

        w_awready   = 1'b0;
        w_wready    = 1'b0;
        w_bvalid    = 1'b0;
        w_bresp     = RESP_OKAY;
        w_valid     = 1'b0;
        w_cen       = 1'b1;
        w_wen       = 1'b1;
        w_aw_take   = 1'b0;

        case (r_state)
            IDLE: begin
                // W beats arriving ahead of AW are held off here
                w_awready = 1'b1;
                w_aw_take = axi.AWVALID_i;
            end

            DATA: begin
                // The request goes out as soon as data is present; the write
                // itself only counts when the arbiter grants in this cycle.
                w_valid  = axi.WVALID_i;
                w_cen    = ~axi.WVALID_i;
                w_wen    = ~axi.WVALID_i;
                w_wready = w_beat_ok;
                if (w_beat_ok) begin
                    // WLAST never ends the burst; a misplaced or missing
                    // WLAST only marks the response as SLVERR.
                    w_err_nxt = r_err | (axi.WLAST_i != w_last_beat);
                    if (w_last_beat) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                        // WRAP and reserved types advance like INCR;
                        // the word address wraps silently at the top.
                        if (!r_fixed) begin
                            w_addr_nxt = r_addr + MEM_ADDR_WIDTH'(1);
                        end
                    end
                end
            end

            RESP: begin
                w_bvalid  = 1'b1;
                w_bresp   = r_err ? RESP_SLVERR : RESP_OKAY;
                // A new AW is only taken together with the B handshake so
                // the latched ID/USER stay valid while BVALID is up.
                w_awready = axi.BREADY_i;
                if (axi.BREADY_i) begin
                    if (axi.AWVALID_i) begin
                        w_aw_take = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_aw_take) begin
            w_state_nxt = DATA;
            w_addr_nxt  = w_aw_word;
            w_len_nxt   = axi.AWLEN_i;
            w_cnt_nxt   = 8'd0;
            w_fixed_nxt = (axi.AWBURST_i == BURST_FIXED);
            w_id_nxt    = axi.AWID_i;
            w_user_nxt  = axi.AWUSER_i;
            w_err_nxt   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign axi.AWREADY_o = w_awready;
    assign axi.WREADY_o  = w_wready;
    assign axi.BVALID_o  = w_bvalid;
    assign axi.BRESP_o   = w_bresp;
    assign axi.BID_o     = r_id;
    assign axi.BUSER_o   = r_user;
    assign axi.valid_o   = w_valid;
    assign axi.MEM_CEN_o = w_cen;
    assign axi.MEM_WEN_o = w_wen;
    assign axi.MEM_A_o   = r_addr;
    assign axi.MEM_D_o   = axi.WDATA_i;
    assign axi.MEM_BE_o  = axi.WSTRB_i;

    // AW attributes that have no effect on a full-width SRAM write
    logic w_unused_inputs;
    assign w_unused_inputs = ^{axi.AWSIZE_i, axi.AWLOCK_i, axi.AWCACHE_i,
                               axi.AWPROT_i, axi.AWREGION_i, axi.AWQOS_i,
                               axi.WUSER_i, axi.AWADDR_i};

endmodule
`default_nettype wire

// File: tb/tb_axi_write_only_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_write_only_ctrl
//  Description : Self-checking bench for axi_write_only_ctrl. Directed table
//                of bursts, hand-written corner sequences and randomized
//                bursts checked against a burst-level memory write model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_write_only_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_write_only_ctrl_if #(
        .AXI4_ADDRESS_WIDTH(32), .AXI4_WDATA_WIDTH(64), .AXI4_ID_WIDTH(16),
        .AXI4_USER_WIDTH(10), .AXI_NUMBYTES(8), .MEM_ADDR_WIDTH(13)
    ) bus ();

    axi_write_only_ctrl #(
        .AXI4_ADDRESS_WIDTH(32), .AXI4_WDATA_WIDTH(64), .AXI4_ID_WIDTH(16),
        .AXI4_USER_WIDTH(10), .AXI_NUMBYTES(8), .MEM_ADDR_WIDTH(13)
    ) dut (
        .clk (clk),
        .rst (rst),
        .axi (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [12:0] a;
        logic [63:0] d;
        logic [7:0]  be;
    } wr_t;

    wr_t wr_log[$];
    wr_t wr_exp[$];

    // Burst-level model of the current AW
    logic [12:0] m_start;
    logic        m_fixed;
    logic [7:0]  m_len;
    logic [15:0] m_id;
    logic [9:0]  m_user;

    // Record every write the SRAM sees (sampled mid-cycle, committed at the next edge)
    always @(negedge clk) begin
        if (!rst && !bus.MEM_CEN_o && !bus.MEM_WEN_o && bus.grant_i)
            wr_log.push_back('{bus.MEM_A_o, bus.MEM_D_o, bus.MEM_BE_o});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic model_aw(input logic [15:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [9:0] user);
        m_start = 13'((addr / 8) % 8192);
        m_fixed = (burst == 2'b00);
        m_len   = len;
        m_id    = id;
        m_user  = user;
    endtask

    task automatic drive_aw(input logic [15:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [9:0] user);
        bus.AWID_i    = id;
        bus.AWADDR_i  = addr;
        bus.AWLEN_i   = len;
        bus.AWBURST_i = burst;
        bus.AWUSER_i  = user;
        bus.AWSIZE_i  = 3'd3;
        bus.AWVALID_i = 1'b1;
    endtask

    task automatic send_aw(input logic [15:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input logic [9:0] user);
        int t = 0;
        drive_aw(id, addr, len, burst, user);
        settle();
        while (!bus.AWREADY_o && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) chk("aw_timeout", 64'(bus.AWREADY_o), 64'd1);
        step();
        bus.AWVALID_i = 1'b0;
        model_aw(id, addr, len, burst, user);
    endtask

    function automatic logic [12:0] beat_addr(input int i);
        return m_fixed ? m_start : 13'((int'(m_start) + i) % 8192);
    endfunction

    task automatic send_w(input int wlast_at, input int stall_beat, input int stall_cycles,
                          input bit rand_grant, input bit rand_data);
        for (int i = 0; i <= int'(m_len); i++) begin
            logic [63:0] d;
            logic [7:0]  s;
            bit          acc;
            int          t;
            d = rand_data ? {$urandom, $urandom} : 64'hDEADBEEF_CAFEF00D + 64'(i);
            s = rand_data ? 8'($urandom) : 8'hFF;
            bus.WVALID_i = 1'b1;
            bus.WDATA_i  = d;
            bus.WSTRB_i  = s;
            bus.WLAST_i  = (i == wlast_at);
            if (i == stall_beat) begin
                for (int c = 0; c < stall_cycles; c++) begin
                    bus.grant_i = 1'b0;
                    settle();
                    chk("stall_wready", 64'(bus.WREADY_o), 64'd0);
                    chk("stall_valid", 64'(bus.valid_o), 64'd1);
                    step();
                end
            end
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 60) begin
                bus.grant_i = rand_grant ? 1'($urandom_range(0, 1)) : 1'b1;
                settle();
                acc = bus.WREADY_o;
                step();
                t++;
            end
            if (!acc) chk("w_timeout", 64'd0, 64'd1);
            wr_exp.push_back('{beat_addr(i), d, s});
        end
        bus.WVALID_i = 1'b0;
        bus.WLAST_i  = 1'b0;
        bus.grant_i  = 1'b1;
    endtask

    task automatic recv_b(input int delay, input logic [1:0] exp_resp);
        bus.BREADY_i = 1'b0;
        settle();
        chk("b_valid", 64'(bus.BVALID_o), 64'd1);
        chk("b_resp", 64'(bus.BRESP_o), 64'(exp_resp));
        chk("b_id", 64'(bus.BID_o), 64'(m_id));
        chk("b_user", 64'(bus.BUSER_o), 64'(m_user));
        for (int d = 0; d < delay; d++) begin
            chk("b_hold_valid", 64'(bus.BVALID_o), 64'd1);
            chk("b_hold_awready", 64'(bus.AWREADY_o), 64'd0);
            step();
        end
        bus.BREADY_i = 1'b1;
        settle();
        chk("b_awready", 64'(bus.AWREADY_o), 64'd1);
        step();
        bus.BREADY_i = 1'b0;
        settle();
        chk("b_done", 64'(bus.BVALID_o), 64'd0);
    endtask

    task automatic check_writes();
        int n;
        chk("wr_count", 64'(wr_log.size()), 64'(wr_exp.size()));
        n = (wr_log.size() < wr_exp.size()) ? wr_log.size() : wr_exp.size();
        for (int i = 0; i < n; i++) begin
            chk("wr_addr", 64'(wr_log[i].a), 64'(wr_exp[i].a));
            chk("wr_data", wr_log[i].d, wr_exp[i].d);
            chk("wr_be", 64'(wr_log[i].be), 64'(wr_exp[i].be));
        end
        wr_log.delete();
        wr_exp.delete();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          wlast_at;
        logic [12:0] exp_first;
        logic [12:0] exp_last;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_0040, 8'd0, 2'b01, 0, 13'h0008, 13'h0008, 2'b00}; // single write
        vecs[1] = '{32'h0000_0100, 8'd3, 2'b01, 3, 13'h0020, 13'h0023, 2'b00}; // INCR
        vecs[2] = '{32'h0000_0200, 8'd2, 2'b00, 2, 13'h0040, 13'h0040, 2'b00}; // FIXED
        vecs[3] = '{32'h0000_FFF8, 8'd1, 2'b01, 1, 13'h1FFF, 13'h0000, 2'b00}; // addr wrap
        vecs[4] = '{32'h0000_0180, 8'd2, 2'b01, 1, 13'h0030, 13'h0032, 2'b10}; // early WLAST
        vecs[5] = '{32'h0000_0400, 8'd3, 2'b10, 3, 13'h0080, 13'h0083, 2'b00}; // WRAP as INCR
        vecs[6] = '{32'h0000_0808, 8'd1, 2'b11, 1, 13'h0101, 13'h0102, 2'b00}; // reserved
        vecs[7] = '{32'h0000_0048, 8'd0, 2'b01, 5, 13'h0009, 13'h0009, 2'b10}; // no WLAST

        bus.AWID_i = '0; bus.AWADDR_i = '0; bus.AWLEN_i = '0; bus.AWSIZE_i = '0;
        bus.AWBURST_i = '0; bus.AWLOCK_i = 1'b0; bus.AWCACHE_i = '0; bus.AWPROT_i = '0;
        bus.AWREGION_i = '0; bus.AWQOS_i = '0; bus.AWUSER_i = '0; bus.AWVALID_i = 1'b0;
        bus.WDATA_i = '0; bus.WSTRB_i = '0; bus.WLAST_i = 1'b0; bus.WUSER_i = '0;
        bus.WVALID_i = 1'b0; bus.BREADY_i = 1'b0; bus.grant_i = 1'b0;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        settle();
        chk("rst_awready", 64'(bus.AWREADY_o), 64'd1);
        chk("rst_wready", 64'(bus.WREADY_o), 64'd0);
        chk("rst_bvalid", 64'(bus.BVALID_o), 64'd0);
        chk("rst_bresp", 64'(bus.BRESP_o), 64'd0);
        chk("rst_bid", 64'(bus.BID_o), 64'd0);
        chk("rst_buser", 64'(bus.BUSER_o), 64'd0);
        chk("rst_cen", 64'(bus.MEM_CEN_o), 64'd1);
        chk("rst_wen", 64'(bus.MEM_WEN_o), 64'd1);
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        step();
        bus.grant_i = 1'b1;

        // ---------------- directed table ----------------
        for (int k = 0; k < 8; k++) begin
            send_aw(16'h1000 + 16'(k), vecs[k].addr, vecs[k].len, vecs[k].burst, 10'h3A0 + 10'(k));
            send_w(vecs[k].wlast_at, -1, 0, 1'b0, 1'b0);
            if (wr_log.size() > 0) begin
                chk("tbl_first_addr", 64'(wr_log[0].a), 64'(vecs[k].exp_first));
                chk("tbl_last_addr", 64'(wr_log[wr_log.size()-1].a), 64'(vecs[k].exp_last));
            end else begin
                chk("tbl_no_write", 64'd0, 64'd1);
            end
            chk("tbl_beats", 64'(wr_log.size()), 64'(vecs[k].len) + 64'd1);
            recv_b(0, vecs[k].exp_resp);
            check_writes();
        end

        // ---------------- grant stall on beat 2 ----------------
        send_aw(16'h0055, 32'h100, 8'd3, 2'b01, 10'h011);
        send_w(3, 2, 3, 1'b0, 1'b1);
        recv_b(0, 2'b00);
        check_writes();

        // ---------------- B backpressure ----------------
        send_aw(16'h0066, 32'h2000, 8'd1, 2'b01, 10'h022);
        send_w(1, -1, 0, 1'b0, 1'b1);
        recv_b(5, 2'b00);
        check_writes();

        // ---------------- back-to-back bursts ----------------
        send_aw(16'h0071, 32'h300, 8'd1, 2'b01, 10'h031);
        send_w(1, -1, 0, 1'b0, 1'b1);
        bus.BREADY_i = 1'b1;
        drive_aw(16'h0077, 32'h500, 8'd0, 2'b01, 10'h037);
        settle();
        chk("b2b_bvalid", 64'(bus.BVALID_o), 64'd1);
        chk("b2b_bid", 64'(bus.BID_o), 64'h0071);
        chk("b2b_awready", 64'(bus.AWREADY_o), 64'd1);
        step();
        bus.BREADY_i  = 1'b0;
        bus.AWVALID_i = 1'b0;
        model_aw(16'h0077, 32'h500, 8'd0, 2'b01, 10'h037);
        bus.WVALID_i = 1'b1;
        bus.grant_i  = 1'b1;
        settle();
        chk("b2b_wready", 64'(bus.WREADY_o), 64'd1);
        chk("b2b_addr", 64'(bus.MEM_A_o), 64'h00A0);
        chk("b2b_bvalid_low", 64'(bus.BVALID_o), 64'd0);
        send_w(0, -1, 0, 1'b0, 1'b1);
        recv_b(0, 2'b00);
        check_writes();

        // ---------------- W before AW ----------------
        bus.WVALID_i = 1'b1;
        bus.WLAST_i  = 1'b1;
        bus.grant_i  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("early_w_wready", 64'(bus.WREADY_o), 64'd0);
            chk("early_w_valid", 64'(bus.valid_o), 64'd0);
            step();
        end
        send_aw(16'h0088, 32'h700, 8'd0, 2'b01, 10'h044);
        send_w(0, -1, 0, 1'b0, 1'b1);
        recv_b(0, 2'b00);
        check_writes();

        // ---------------- reset mid-burst ----------------
        send_aw(16'h0099, 32'h600, 8'd3, 2'b01, 10'h055);
        bus.WVALID_i = 1'b1;
        bus.WDATA_i  = 64'h0123_4567_89AB_CDEF;
        bus.WSTRB_i  = 8'h0F;
        bus.grant_i  = 1'b1;
        settle();
        chk("mid_rst_wready", 64'(bus.WREADY_o), 64'd1);
        wr_exp.push_back('{beat_addr(0), 64'h0123_4567_89AB_CDEF, 8'h0F});
        step();
        bus.WVALID_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        chk("mid_rst_bvalid", 64'(bus.BVALID_o), 64'd0);
        chk("mid_rst_awready", 64'(bus.AWREADY_o), 64'd1);
        chk("mid_rst_cen", 64'(bus.MEM_CEN_o), 64'd1);
        step();
        chk("mid_rst_bvalid2", 64'(bus.BVALID_o), 64'd0);
        check_writes();

        // ---------------- randomized bursts vs model ----------------
        for (int r = 0; r < 40; r++) begin
            logic [31:0] a;
            logic [7:0]  l;
            logic [1:0]  b;
            int          wl;
            a  = $urandom;
            l  = 8'($urandom_range(0, 7));
            b  = 2'($urandom_range(0, 3));
            wl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : int'(l);
            send_aw(16'($urandom), a, l, b, 10'($urandom));
            send_w(wl, -1, 0, 1'b1, 1'b1);
            recv_b(int'($urandom_range(0, 3)), (wl != int'(l)) ? 2'b10 : 2'b00);
            check_writes();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
